// File: rtl/pulse_event_arbiter.sv
// Round-robin arbiter that turns rising edges on N_REQ event lines into 4-phase req/ack grants.
// Optional ack timeout is compiled in with `define PULSE_ARB_TIMEOUT_EN.
module pulse_event_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           ev_in,
    input  logic                       out_ack,
    input  logic                       ovf_clr,
    output logic                       out_req,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    output logic [N_REQ-1:0]           ovf,
    output logic                       busy,
    output logic                       timeout
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

    state_t                        state, state_nxt;
    logic [N_REQ-1:0]              ev_q;
    logic [N_REQ-1:0]              det;
    logic [N_REQ-1:0][CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_REQ-1:0]              ovf_nxt, ovf_set;
    logic [ID_W-1:0]               rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]               out_id_nxt;
    logic [ID_W-1:0]               sel, cand;
    logic                          found, grant;
    logic                          out_req_nxt, busy_nxt, timeout_nxt;
    int unsigned                   idx;
`ifdef PULSE_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'd254;
    logic [7:0]                    to_cnt, to_cnt_nxt;
`endif

    assign det = ev_in & ~ev_q;

    // Next-state, grant selection, counter and flag update
    always_comb begin
        state_nxt   = state;
        out_req_nxt = out_req;
        out_id_nxt  = out_id;
        rr_ptr_nxt  = rr_ptr;
        timeout_nxt = 1'b0;
        grant       = 1'b0;
        found       = 1'b0;
        sel         = rr_ptr;
        cand        = '0;
        idx         = 0;
        cnt_nxt     = cnt;
        ovf_set     = '0;
`ifdef PULSE_ARB_TIMEOUT_EN
        to_cnt_nxt  = to_cnt;
`endif

        // First nonzero counter at or above rr_ptr, wrapping
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx  = (32'(rr_ptr) + k) % N_REQ;
            cand = ID_W'(idx);
            if (!found && cnt[cand] != '0) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    grant       = 1'b1;
                    out_req_nxt = 1'b1;
                    out_id_nxt  = sel;
                    rr_ptr_nxt  = (32'(sel) == N_REQ - 1) ? '0 : ID_W'(32'(sel) + 32'd1);
                    state_nxt   = REQ;
`ifdef PULSE_ARB_TIMEOUT_EN
                    to_cnt_nxt  = 8'd0;
`endif
                end
            end
            REQ: begin
                if (out_ack) begin
                    out_req_nxt = 1'b0;
                    state_nxt   = WAIT_LOW;
                end
`ifdef PULSE_ARB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    out_req_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    to_cnt_nxt  = to_cnt + 8'd1;
                end
`endif
            end
            WAIT_LOW: begin
                if (!out_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                out_req_nxt = 1'b0;
            end
        endcase

        // Simultaneous increment and grant-decrement cancel out
        for (int i = 0; i < N_REQ; i++) begin
            if (det[i] && !(grant && sel == ID_W'(i))) begin
                if (cnt[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end else if (!det[i] && grant && sel == ID_W'(i)) begin
                cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
        end

        ovf_nxt  = (ovf & ~{N_REQ{ovf_clr}}) | ovf_set;
        busy_nxt = (state_nxt != IDLE) || (cnt_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ev_q    <= '0;
            cnt     <= '0;
            ovf     <= '0;
            rr_ptr  <= '0;
            out_req <= 1'b0;
            out_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ev_q    <= ev_in;
            cnt     <= cnt_nxt;
            ovf     <= ovf_nxt;
            rr_ptr  <= rr_ptr_nxt;
            out_req <= out_req_nxt;
            out_id  <= out_id_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
        end
    end

`ifdef PULSE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= 8'd0;
        end else begin
            to_cnt <= to_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed self-checking bench for pulse_event_arbiter (N_REQ=4, CNT_W=3).
module tb_pulse_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ev_in;
    logic       out_ack;
    logic       ovf_clr;
    logic       out_req;
    logic [1:0] out_id;
    logic [3:0] ovf;
    logic       busy;
    logic       timeout;

    logic       ack_auto, ack_man, ack_dly;
    logic       req_prev;
    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    int         n;
    logic [1:0] grants[$];

    pulse_event_arbiter #(.N_REQ(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ev_in   (ev_in),
        .out_ack (out_ack),
        .ovf_clr (ovf_clr),
        .out_req (out_req),
        .out_id  (out_id),
        .ovf     (ovf),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Downstream channel model: ack follows req one cycle later when enabled
    always @(posedge clk) ack_dly <= out_req;
    assign out_ack = ack_auto ? ack_dly : ack_man;

    // Log the id of every new grant
    always @(negedge clk) begin
        if (out_req && !req_prev) grants.push_back(out_id);
        req_prev = out_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ev_in    = '0;
        ack_man  = 1'b0;
        ack_auto = 1'b0;
        ovf_clr  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        grants.delete();
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int c;
        c = 0;
        while (busy && c < max_cyc) begin
            step();
            c++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ev_in = '0; ack_man = 1'b0; ack_auto = 1'b0; ovf_clr = 1'b0; req_prev = 1'b0;
        #1;
        chk("rst_out_req", 32'(out_req), 32'd0);
        chk("rst_out_id",  32'(out_id),  32'd0);
        chk("rst_ovf",     32'(ovf),     32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // Single pulse on source 2 with delayed ack loopback
        do_reset();
        ack_auto = 1'b1;
        ev_in = 4'b0100; step();
        chk("t1_busy_on",   32'(busy),    32'd1);
        chk("t1_no_req_yet", 32'(out_req), 32'd0);
        ev_in = 4'b0000; step();
        chk("t1_req",  32'(out_req), 32'd1);
        chk("t1_id",   32'(out_id),  32'd2);
        step();
        chk("t1_req_hold", 32'(out_req), 32'd1);
        step();
        chk("t1_req_drop", 32'(out_req), 32'd0);
        step();
        chk("t1_busy_wait_low", 32'(busy), 32'd1);
        step();
        chk("t1_busy_off", 32'(busy), 32'd0);
        chk("t1_id_hold",  32'(out_id), 32'd2);
        chk("t1_ngrants",  32'(grants.size()), 32'd1);

        // Simultaneous events on all sources, round-robin from 0
        do_reset();
        ack_auto = 1'b1;
        ev_in = 4'b1111; step();
        ev_in = 4'b0000;
        wait_idle("t2_idle", 100);
        chk("t2_ngrants", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) chk($sformatf("t2_order%0d", i), 32'(grants[i]), 32'(i));
        end
        grants.delete();
        ev_in = 4'b1001; step();
        ev_in = 4'b0000;
        wait_idle("t2b_idle", 100);
        chk("t2b_ngrants", 32'(grants.size()), 32'd2);
        if (grants.size() > 0) chk("t2b_first_is_0", 32'(grants[0]), 32'd0);

        // Overflow on source 1 while ack held low
        do_reset();
        for (int k = 0; k < 9; k++) begin
            ev_in = 4'b0010; step();
            chk($sformatf("t3_ovf_ev%0d", k + 1), 32'(ovf), (k == 8) ? 32'd2 : 32'd0);
            ev_in = 4'b0000; step();
        end
        chk("t3_req", 32'(out_req), 32'd1);
        chk("t3_id",  32'(out_id),  32'd1);
        ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(ovf), 32'd0);
        ev_in = 4'b0010; ovf_clr = 1'b1; step();
        chk("t3_set_wins", 32'(ovf), 32'd2);
        ev_in = 4'b0000; ovf_clr = 1'b0; step();
        ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr2", 32'(ovf), 32'd0);
        ack_auto = 1'b1;
        wait_idle("t3_idle", 200);
        chk("t3_ngrants", 32'(grants.size()), 32'd8);

        // Event on source 3 on the same edge as its grant
        do_reset();
        ev_in = 4'b1001; step();
        ev_in = 4'b0000; step();
        chk("t4_req0", 32'(out_req), 32'd1);
        chk("t4_id0",  32'(out_id),  32'd0);
        ack_man = 1'b1; step();
        chk("t4_req0_drop", 32'(out_req), 32'd0);
        ack_man = 1'b0; step();
        ev_in = 4'b1000; step();
        chk("t4_req3", 32'(out_req), 32'd1);
        chk("t4_id3",  32'(out_id),  32'd3);
        ev_in = 4'b0000; ack_auto = 1'b1;
        wait_idle("t4_idle", 100);
        chk("t4_ngrants", 32'(grants.size()), 32'd3);
        if (grants.size() == 3) begin
            chk("t4_g1", 32'(grants[1]), 32'd3);
            chk("t4_g2", 32'(grants[2]), 32'd3);
        end

        // Asynchronous reset during REQ with two events pending on source 0
        do_reset();
        ev_in = 4'b0001; step();
        ev_in = 4'b0000; step();
        for (int k = 0; k < 2; k++) begin
            ev_in = 4'b0001; step();
            ev_in = 4'b0000; step();
        end
        chk("t5_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_req", 32'(out_req), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        grants.delete();
        ack_auto = 1'b1;
        for (int k = 0; k < 20; k++) step();
        chk("t5_no_grants", 32'(grants.size()), 32'd0);
        chk("t5_busy_post", 32'(busy), 32'd0);

        // Level held high through reset release counts as an event
        rst_n = 1'b0; ack_auto = 1'b0; ev_in = 4'b0100;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_no_req", 32'(out_req), 32'd0);
        step();
        chk("t6_req", 32'(out_req), 32'd1);
        chk("t6_id",  32'(out_id),  32'd2);
        ev_in = 4'b0000;

        // Ack stuck low
        do_reset();
        ev_in = 4'b0011; step();
        ev_in = 4'b0000; step();
        chk("t7_req0", 32'(out_req), 32'd1);
`ifdef PULSE_ARB_TIMEOUT_EN
        n = 0;
        while (out_req && n < 300) begin
            step();
            n++;
            if (out_req) chk("t7_no_early_to", 32'(timeout), 32'd0);
        end
        chk("t7_to_edges", 32'(n), 32'd255);
        chk("t7_to_pulse", 32'(timeout), 32'd1);
        step();
        chk("t7_to_single", 32'(timeout), 32'd0);
        chk("t7_next_req", 32'(out_req), 32'd1);
        chk("t7_next_id",  32'(out_id),  32'd1);
`else
        n = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (timeout) n++;
        end
        chk("t7_req_waits", 32'(out_req), 32'd1);
        chk("t7_id_waits",  32'(out_id),  32'd0);
        chk("t7_no_timeout", 32'(n), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
